piso_ser: RTL and testbench

PISO_SER -- requirements
Module: piso_ser

---
 rtl/piso_ser.sv | 51 +++++
 tb/tb_piso_ser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/piso_ser.sv
// piso_ser: parallel-in serial-out shifter with ready/load handshake and stall support
module piso_ser #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D,
   input  logic             load,
   output logic             ready,
   input  logic             shift_en,
   input  logic             Din,
   output logic             Qout,
   output logic [WIDTH-1:0] Q_all,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic final_shift, accept;
   logic [WIDTH-1:0] shifted;
   assign busy        = state == SHIFT;
   assign final_shift = busy && shift_en && cnt == CW'(WIDTH - 1);
   assign ready       = !busy || final_shift;
   assign accept      = load && ready;
   assign shifted     = MSB_FIRST ? {Q_all[WIDTH-2:0], Din} : {Din, Q_all[WIDTH-1:1]};
   assign Qout        = busy ? (MSB_FIRST ? Q_all[WIDTH-1] : Q_all[0]) : IDLE_LEVEL;
   // load wins over the shift result so back-to-back words leave no gap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         Q_all <= '0;
         done  <= 1'b0;
      end else begin
         done <= final_shift;
         if (accept) begin
            Q_all <= D;
            cnt   <= '0;
            state <= SHIFT;
         end else if (busy && shift_en) begin
            Q_all <= shifted;
            cnt   <= cnt + 1'b1;
            state <= final_shift ? IDLE : SHIFT;
         end
      end
   end
endmodule

// File: tb/tb_piso_ser.sv
// tb_piso_ser: MSB-first and LSB-first instances against a bit-position reference model
module tb_piso_ser;
   localparam int W = 4;
   logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, shift_en = 1'b0, din = 1'b0;
   logic [W-1:0] d = '0;
   logic rdy[2], qo[2], bsy[2], dn[2];
   logic [W-1:0] qa[2];
   int checks = 0, fails = 0, dones;
   bit m_busy[2], m_done[2];
   int m_k[2];
   logic [W-1:0] m_word[2], m_q[2];
   bit m_fb[2][W];
   logic [3:0] pat, fill;
   logic [7:0] seq;

   always #5 clk = ~clk;

   piso_ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .D(d), .load(load), .ready(rdy[0]), .shift_en(shift_en),
      .Din(din), .Qout(qo[0]), .Q_all(qa[0]), .busy(bsy[0]), .done(dn[0]));

   piso_ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .D(d), .load(load), .ready(rdy[1]), .shift_en(shift_en),
      .Din(din), .Qout(qo[1]), .Q_all(qa[1]), .busy(bsy[1]), .done(dn[1]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // register contents after k shifts: word moved k places, fill bit j sits where it has drifted to
   function automatic logic [W-1:0] compose(int m);
      logic [W-1:0] r;
      r = (m == 0) ? m_word[m] << m_k[m] : m_word[m] >> m_k[m];
      for (int j = 0; j < m_k[m]; j++)
         if (m_fb[m][j]) r[(m == 0) ? m_k[m] - 1 - j : W - m_k[m] + j] = 1'b1;
      return r;
   endfunction

   task automatic model_update();
      for (int m = 0; m < 2; m++) begin
         bit fin;
         fin = m_busy[m] && shift_en && m_k[m] == W - 1;
         if (!rst_n) begin
            m_busy[m] = 0; m_done[m] = 0; m_k[m] = 0; m_q[m] = '0;
         end else begin
            m_done[m] = fin;
            if (load && (!m_busy[m] || fin)) begin
               m_word[m] = d; m_k[m] = 0; m_busy[m] = 1; m_q[m] = d;
            end else if (m_busy[m] && shift_en) begin
               m_fb[m][m_k[m]] = din;
               m_k[m]++;
               m_q[m] = compose(m);
               if (m_k[m] == W) m_busy[m] = 0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      for (int m = 0; m < 2; m++) begin
         bit er, eq;
         er = !m_busy[m] || (shift_en && m_k[m] == W - 1);
         eq = m_busy[m] ? m_word[m][(m == 0) ? W - 1 - m_k[m] : m_k[m]] : (m == 1);
         chk($sformatf("u%0d_ready", m), rdy[m], er);
         chk($sformatf("u%0d_busy", m), bsy[m], m_busy[m]);
         chk($sformatf("u%0d_done", m), dn[m], m_done[m]);
         chk($sformatf("u%0d_qall", m), qa[m], m_q[m]);
         chk($sformatf("u%0d_qout", m), qo[m], eq);
      end
   endtask

   task automatic step();
      #2 check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      model_update();
      #1 rst_n = 1'b1;
      #1 chk("rst_busy", bsy[0], 0);
      chk("rst_ready", rdy[0], 1);
      chk("rst_qall", qa[0], 0);
      chk("rst_idle_lsb", qo[1], 1);
      step();
      // MSB-first word 1010 with fills 1,1,0,0; the LSB instance sees the same load
      pat = 4'b1010; fill = 4'b1100;
      d = pat; load = 1'b1; step();
      load = 1'b0; shift_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = fill[3-i];
         #1 chk("msb_qout", qo[0], pat[3-i]);
         chk("lsb_qout", qo[1], pat[i]);
         step();
      end
      shift_en = 1'b0;
      #1 chk("msb_qall_end", qa[0], 4'b1100);
      chk("msb_done", dn[0], 1);
      chk("msb_busy_end", bsy[0], 0);
      step();
      // stall of five cycles after the first shift
      pat = 4'b1001; d = pat; load = 1'b1; step();
      load = 1'b0; shift_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            shift_en = 1'b0;
            repeat (5) begin
               din = 1'($urandom);
               #1 chk("stall_qout", qo[0], pat[2]);
               step();
            end
            shift_en = 1'b1;
         end
         #1 chk("stall_seq", qo[0], pat[3-i]);
         step();
      end
      shift_en = 1'b0; step();
      // back-to-back words 1100 then 0011
      seq = 8'b11000011; dones = 0;
      d = 4'b1100; load = 1'b1; step();
      shift_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         load = (i == 3);
         if (i == 3) d = 4'b0011;
         #1 chk("b2b_qout", qo[0], seq[7-i]);
         chk("b2b_busy", bsy[0], 1);
         if (dn[0]) dones++;
         step();
      end
      load = 1'b0; shift_en = 1'b0;
      #1 if (dn[0]) dones++;
      chk("b2b_dones", dones, 2);
      step();
      // load while busy is ignored
      d = 4'b1111; load = 1'b1; step();
      shift_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load = (i == 1);
         if (i == 1) d = 4'b0000;
         #1 chk("ign_msb", qo[0], 1);
         chk("ign_lsb", qo[1], 1);
         step();
      end
      load = 1'b0; shift_en = 1'b0; step();
      // reset at cnt=2 aborts the word silently
      d = 4'b0110; load = 1'b1; step();
      load = 1'b0; shift_en = 1'b1;
      step(); step();
      rst_n = 1'b0; load = 1'b1; step();
      rst_n = 1'b1; load = 1'b0; shift_en = 1'b0;
      #1 chk("rst_mid_busy", bsy[0], 0);
      chk("rst_mid_ready", rdy[0], 1);
      chk("rst_mid_qall", qa[0], 0);
      chk("rst_mid_qout_msb", qo[0], 0);
      chk("rst_mid_qout_lsb", qo[1], 1);
      repeat (3) begin
         #1 chk("rst_mid_nodone", dn[0], 0);
         step();
      end
      // random traffic
      repeat (3000) begin
         rst_n = ($urandom_range(0, 63) != 0);
         load = ($urandom_range(0, 3) == 0);
         shift_en = ($urandom_range(0, 3) != 0);
         din = 1'($urandom);
         d = W'($urandom);
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
